lcd_scroller: RTL and testbench

Message sequencer for the VIM828 LCD driver.
- Holds a buffer of up to MAX_LEN 15-bit segment bitmaps, loaded through a valid/ready write port.
- Drives the driver's eight Bitmap inputs (digit 7 = leftmost) with either a static window or a timed left-scrolling window.
- Sits between the host logic and the LCD driver; it does not touch COM/SEG waveform generation.

---
 rtl/lcd_scroller.sv | 188 ++++++++++++++++++
 tb/tb_lcd_scroller.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_scroller.sv
// lcd_scroller: message sequencer feeding the eight Bitmap inputs of the
// VIM828 LCD driver. A host loads up to MAX_LEN 15-bit segment bitmaps and
// then shows them as a static window or as a timed left-scrolling window.
// Optional feature macro: LCD_SCROLLER_TAIL_EN (scroll every message fully
// off the left edge with blank fill).
module lcd_scroller #(
  parameter int CLOCK_HZ  = 1_000_000,
  parameter int SCROLL_US = 250_000,
  parameter int MAX_LEN   = 32
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [14:0] WrData_i,
  input  logic        WrValid_i,
  output logic        WrReady_o,
  input  logic        Clear_i,
  input  logic        Start_i,
  input  logic        Stop_i,
  input  logic        Loop_i,
  output logic        Busy_o,
  output logic        Done_o,
  output logic [14:0] Bitmap7_o,
  output logic [14:0] Bitmap6_o,
  output logic [14:0] Bitmap5_o,
  output logic [14:0] Bitmap4_o,
  output logic [14:0] Bitmap3_o,
  output logic [14:0] Bitmap2_o,
  output logic [14:0] Bitmap1_o,
  output logic [14:0] Bitmap0_o
);

  localparam int STEP_TICKS = CLOCK_HZ / 1_000_000 * SCROLL_US;
  localparam int CW = $clog2(MAX_LEN + 1);
  localparam int AW = $clog2(MAX_LEN);
  localparam int TW = (STEP_TICKS > 1) ? $clog2(STEP_TICKS) : 1;

  typedef enum logic [0:0] {
    S_IDLE   = 1'b0,
    S_SCROLL = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] len_q, len_d;
  logic [CW-1:0] pos_q, pos_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          done_q, done_d;
  // refresh_q requests a window reload from the (already updated) Pos/Len
  logic          refresh_q, refresh_d;
  logic [14:0]   buf_q [MAX_LEN];
  logic [14:0]   bitmap_q [8];
  logic [14:0]   win_s [8];
  logic          wr_en_s;
  logic [CW-1:0] last_pos_s;
  logic          wrap_s;

  assign WrReady_o = (state_q == S_IDLE) && (len_q < CW'(MAX_LEN)) && !Clear_i;
  assign wr_en_s   = WrValid_i && WrReady_o;
  assign wrap_s    = (timer_q == TW'(STEP_TICKS - 1));
`ifdef LCD_SCROLLER_TAIL_EN
  assign last_pos_s = len_q;
`else
  assign last_pos_s = len_q - CW'(8);
`endif

  assign Busy_o    = (state_q == S_SCROLL);
  assign Done_o    = done_q;
  assign Bitmap7_o = bitmap_q[7];
  assign Bitmap6_o = bitmap_q[6];
  assign Bitmap5_o = bitmap_q[5];
  assign Bitmap4_o = bitmap_q[4];
  assign Bitmap3_o = bitmap_q[3];
  assign Bitmap2_o = bitmap_q[2];
  assign Bitmap1_o = bitmap_q[1];
  assign Bitmap0_o = bitmap_q[0];

  // Window selection: digit 7-k shows entry Pos+k, blank past the message end
  always_comb begin : win_comb
    logic [CW:0] idx;
    for (int k = 0; k < 8; k++) begin
      idx = {1'b0, pos_q} + (CW+1)'(k);
      if (idx < {1'b0, len_q}) begin
        win_s[7-k] = buf_q[idx[AW-1:0]];
      end else begin
        win_s[7-k] = 15'd0;
      end
    end
  end

  // Next-state logic for the IDLE/SCROLL sequencer, counters and Done pulse
  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    pos_d     = pos_q;
    timer_d   = timer_q;
    done_d    = 1'b0;
    refresh_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (Clear_i) begin
          len_d = {CW{1'b0}};
        end else begin
          // a write in the same cycle as Start is counted by that Start
          if (wr_en_s) begin
            len_d = len_q + CW'(1);
          end else begin
            len_d = len_q;
          end
          if (Start_i && (len_d != {CW{1'b0}})) begin
            pos_d     = {CW{1'b0}};
            refresh_d = 1'b1;
`ifdef LCD_SCROLLER_TAIL_EN
            timer_d = {TW{1'b0}};
            state_d = S_SCROLL;
`else
            if (len_d <= CW'(8)) begin
              done_d = 1'b1;
            end else begin
              timer_d = {TW{1'b0}};
              state_d = S_SCROLL;
            end
`endif
          end else begin
            pos_d = pos_q;
          end
        end
      end
      S_SCROLL: begin
        if (Stop_i) begin
          state_d = S_IDLE;
        end else if (wrap_s) begin
          timer_d = {TW{1'b0}};
          if (pos_q == last_pos_s) begin
            done_d = 1'b1;
            if (Loop_i) begin
              pos_d     = {CW{1'b0}};
              refresh_d = 1'b1;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            pos_d     = pos_q + CW'(1);
            refresh_d = 1'b1;
          end
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, counters, Done pulse and registered window outputs
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q   <= S_IDLE;
      len_q     <= {CW{1'b0}};
      pos_q     <= {CW{1'b0}};
      timer_q   <= {TW{1'b0}};
      done_q    <= 1'b0;
      refresh_q <= 1'b0;
      for (int k = 0; k < 8; k++) begin
        bitmap_q[k] <= 15'd0;
      end
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      pos_q     <= pos_d;
      timer_q   <= timer_d;
      done_q    <= done_d;
      refresh_q <= refresh_d;
      if (refresh_q) begin
        for (int k = 0; k < 8; k++) begin
          bitmap_q[k] <= win_s[k];
        end
      end
    end
  end

  // Message buffer storage; Len bounds the valid entries, so no reset needed
  always_ff @(posedge Clock) begin
    if (!Reset && wr_en_s) begin
      buf_q[len_q[AW-1:0]] <= WrData_i;
    end
  end

endmodule

// File: tb/tb_lcd_scroller.sv
// Directed self-checking bench for lcd_scroller (STEP_TICKS = 50).
module tb_lcd_scroller;

  logic        Clock = 1'b0;
  logic        Reset = 1'b0;
  logic [14:0] WrData_i = 15'd0;
  logic        WrValid_i = 1'b0;
  logic        Clear_i = 1'b0;
  logic        Start_i = 1'b0;
  logic        Stop_i = 1'b0;
  logic        Loop_i = 1'b0;
  logic        WrReady_o, Busy_o, Done_o;
  logic [14:0] Bitmap7_o, Bitmap6_o, Bitmap5_o, Bitmap4_o;
  logic [14:0] Bitmap3_o, Bitmap2_o, Bitmap1_o, Bitmap0_o;
  logic [119:0] cur_win;

  int n_cmp = 0;
  int n_bad = 0;

  lcd_scroller #(.CLOCK_HZ(1_000_000), .SCROLL_US(50), .MAX_LEN(32)) dut (
    .Clock(Clock), .Reset(Reset),
    .WrData_i(WrData_i), .WrValid_i(WrValid_i), .WrReady_o(WrReady_o),
    .Clear_i(Clear_i), .Start_i(Start_i), .Stop_i(Stop_i), .Loop_i(Loop_i),
    .Busy_o(Busy_o), .Done_o(Done_o),
    .Bitmap7_o(Bitmap7_o), .Bitmap6_o(Bitmap6_o), .Bitmap5_o(Bitmap5_o),
    .Bitmap4_o(Bitmap4_o), .Bitmap3_o(Bitmap3_o), .Bitmap2_o(Bitmap2_o),
    .Bitmap1_o(Bitmap1_o), .Bitmap0_o(Bitmap0_o)
  );

  always #5 Clock = ~Clock;

  assign cur_win = {Bitmap7_o, Bitmap6_o, Bitmap5_o, Bitmap4_o,
                    Bitmap3_o, Bitmap2_o, Bitmap1_o, Bitmap0_o};

  // Expected window when entry i holds value i+1: leftmost digit = entry pos
  function automatic logic [119:0] mk_win(input int pos, input int len);
    logic [119:0] r;
    r = '0;
    for (int k = 0; k < 8; k++) begin
      if (pos + k < len) r[(7-k)*15 +: 15] = 15'(pos + k + 1);
    end
    return r;
  endfunction

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    Reset = 1'b1; WrValid_i = 1'b0; Clear_i = 1'b0; Start_i = 1'b0;
    Stop_i = 1'b0; Loop_i = 1'b0;
    run(2);
    Reset = 1'b0;
  endtask

  // writes n entries holding values first, first+1, ...
  task automatic write_seq(input int first, input int n);
    for (int i = 0; i < n; i++) begin
      WrValid_i = 1'b1; WrData_i = 15'(first + i);
      step();
    end
    WrValid_i = 1'b0;
  endtask

  task automatic start_pulse();
    Start_i = 1'b1;
    step();
    Start_i = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (cur_win !== 120'd0) begin n_bad++; $display("FAIL reset_win got %h want 0", cur_win); end
    n_cmp++; if ({Busy_o, Done_o, WrReady_o} !== 3'b001) begin n_bad++; $display("FAIL reset_flags got %b want 001", {Busy_o, Done_o, WrReady_o}); end
  endtask

  task automatic test_static();
    logic [119:0] exp_w;
    do_reset();
    WrValid_i = 1'b1; WrData_i = 15'h0001; step();
    WrData_i = 15'h0002; step();
    WrData_i = 15'h0004; step();
    WrValid_i = 1'b0;
    start_pulse();
    n_cmp++; if ({Done_o, Busy_o} !== 2'b10) begin n_bad++; $display("FAIL static_done got %b want 10", {Done_o, Busy_o}); end
    step();
    exp_w = {15'h0001, 15'h0002, 15'h0004, 75'd0};
    n_cmp++; if (cur_win !== exp_w) begin n_bad++; $display("FAIL static_win got %h want %h", cur_win, exp_w); end
    n_cmp++; if ({Done_o, Busy_o} !== 2'b00) begin n_bad++; $display("FAIL static_done_end got %b want 00", {Done_o, Busy_o}); end
  endtask

  task automatic scroll_common(input logic loop_en);
    do_reset();
    write_seq(1, 10);
    Loop_i = loop_en;
    start_pulse();                  // now just after edge E0
    n_cmp++; if (Busy_o !== 1'b1) begin n_bad++; $display("FAIL scroll_busy got %b want 1", Busy_o); end
    step();                         // E1
    n_cmp++; if (cur_win !== mk_win(0, 10)) begin n_bad++; $display("FAIL scroll_w0 got %h want %h", cur_win, mk_win(0, 10)); end
    run(49);                        // E50: Pos advanced, window one cycle behind
    n_cmp++; if (cur_win !== mk_win(0, 10)) begin n_bad++; $display("FAIL scroll_w0_hold got %h want %h", cur_win, mk_win(0, 10)); end
    step();                         // E51
    n_cmp++; if (cur_win !== mk_win(1, 10)) begin n_bad++; $display("FAIL scroll_w1 got %h want %h", cur_win, mk_win(1, 10)); end
    run(50);                        // E101
    n_cmp++; if (cur_win !== mk_win(2, 10)) begin n_bad++; $display("FAIL scroll_w2 got %h want %h", cur_win, mk_win(2, 10)); end
    run(48);                        // E149
    n_cmp++; if (Done_o !== 1'b0) begin n_bad++; $display("FAIL scroll_early_done got %b want 0", Done_o); end
    step();                         // E150
    n_cmp++; if ({Done_o, Busy_o} !== {1'b1, loop_en}) begin n_bad++; $display("FAIL scroll_done got %b want %b", {Done_o, Busy_o}, {1'b1, loop_en}); end
    step();                         // E151
    n_cmp++; if (Done_o !== 1'b0) begin n_bad++; $display("FAIL scroll_done_pulse got %b want 0", Done_o); end
  endtask

  task automatic test_single_pass();
    scroll_common(1'b0);
    n_cmp++; if ({cur_win, Busy_o} !== {mk_win(2, 10), 1'b0}) begin n_bad++; $display("FAIL pass_final got %h/%b want %h/0", cur_win, Busy_o, mk_win(2, 10)); end
  endtask

  task automatic test_loop_stop();
    int dones;
    scroll_common(1'b1);
    n_cmp++; if ({cur_win, Busy_o} !== {mk_win(0, 10), 1'b1}) begin n_bad++; $display("FAIL loop_restart got %h/%b want %h/1", cur_win, Busy_o, mk_win(0, 10)); end
    run(23);                        // E174
    Stop_i = 1'b1;
    step();                         // E175
    Stop_i = 1'b0;
    n_cmp++; if (Busy_o !== 1'b0) begin n_bad++; $display("FAIL stop_busy got %b want 0", Busy_o); end
    dones = 0;
    for (int i = 0; i < 120; i++) begin
      step();
      if (Done_o === 1'b1) dones++;
    end
    n_cmp++; if (dones !== 0) begin n_bad++; $display("FAIL stop_no_done got %0d want 0", dones); end
    n_cmp++; if (cur_win !== mk_win(0, 10)) begin n_bad++; $display("FAIL stop_frozen got %h want %h", cur_win, mk_win(0, 10)); end
    Loop_i = 1'b0;
  endtask

  task automatic test_full_clear();
    do_reset();
    write_seq(1, 32);
    n_cmp++; if (WrReady_o !== 1'b0) begin n_bad++; $display("FAIL full_ready got %b want 0", WrReady_o); end
    write_seq(15'h7FFF, 1);
    start_pulse();
    n_cmp++; if (Busy_o !== 1'b1) begin n_bad++; $display("FAIL full_busy got %b want 1", Busy_o); end
    step();
    n_cmp++; if (cur_win !== mk_win(0, 32)) begin n_bad++; $display("FAIL full_win got %h want %h", cur_win, mk_win(0, 32)); end
    run(50);                        // E51
    n_cmp++; if (cur_win !== mk_win(1, 32)) begin n_bad++; $display("FAIL full_win1 got %h want %h", cur_win, mk_win(1, 32)); end
    Stop_i = 1'b1; step(); Stop_i = 1'b0;
    Clear_i = 1'b1; #1;
    n_cmp++; if (WrReady_o !== 1'b0) begin n_bad++; $display("FAIL clear_ready_low got %b want 0", WrReady_o); end
    step();
    Clear_i = 1'b0; #1;
    n_cmp++; if (WrReady_o !== 1'b1) begin n_bad++; $display("FAIL clear_ready got %b want 1", WrReady_o); end
    start_pulse();
    n_cmp++; if ({Done_o, Busy_o} !== 2'b00) begin n_bad++; $display("FAIL clear_start got %b want 00", {Done_o, Busy_o}); end
    step();
    n_cmp++; if (cur_win !== mk_win(1, 32)) begin n_bad++; $display("FAIL clear_win got %h want %h", cur_win, mk_win(1, 32)); end
    write_seq(1, 1);
    start_pulse();
    step();
    n_cmp++; if (cur_win !== mk_win(0, 1)) begin n_bad++; $display("FAIL clear_len0 got %h want %h", cur_win, mk_win(0, 1)); end
  endtask

  task automatic test_reset_conflicts();
    do_reset();
    write_seq(1, 10);
    start_pulse();
    run(60);
    Reset = 1'b1; step(); Reset = 1'b0;
    n_cmp++; if ({cur_win, Busy_o, Done_o} !== 122'd0) begin n_bad++; $display("FAIL midreset got %h/%b/%b want 0", cur_win, Busy_o, Done_o); end
    start_pulse();
    n_cmp++; if ({Done_o, Busy_o} !== 2'b00) begin n_bad++; $display("FAIL midreset_len0 got %b want 00", {Done_o, Busy_o}); end
    write_seq(1, 3);
    start_pulse();
    step();
    Clear_i = 1'b1; Start_i = 1'b1;
    step();
    Clear_i = 1'b0; Start_i = 1'b0;
    n_cmp++; if ({Done_o, Busy_o} !== 2'b00) begin n_bad++; $display("FAIL clrstart_done got %b want 00", {Done_o, Busy_o}); end
    step();
    n_cmp++; if (cur_win !== mk_win(0, 3)) begin n_bad++; $display("FAIL clrstart_win got %h want %h", cur_win, mk_win(0, 3)); end
  endtask

  task automatic test_write_start();
    do_reset();
    write_seq(1, 7);
    WrValid_i = 1'b1; WrData_i = 15'd8; Start_i = 1'b1;
    step();
    WrValid_i = 1'b0; Start_i = 1'b0;
    n_cmp++; if ({Done_o, Busy_o} !== 2'b10) begin n_bad++; $display("FAIL wrstart8 got %b want 10", {Done_o, Busy_o}); end
    step();
    n_cmp++; if (cur_win !== mk_win(0, 8)) begin n_bad++; $display("FAIL wrstart8_win got %h want %h", cur_win, mk_win(0, 8)); end
    WrValid_i = 1'b1; WrData_i = 15'd9; Start_i = 1'b1;
    step();
    WrValid_i = 1'b0; Start_i = 1'b0;
    n_cmp++; if ({Done_o, Busy_o} !== 2'b01) begin n_bad++; $display("FAIL wrstart9 got %b want 01", {Done_o, Busy_o}); end
    Stop_i = 1'b1; step(); Stop_i = 1'b0;
  endtask

`ifdef LCD_SCROLLER_TAIL_EN
  task automatic test_tail();
    do_reset();
    write_seq(1, 3);
    start_pulse();
    n_cmp++; if (Busy_o !== 1'b1) begin n_bad++; $display("FAIL tail_busy got %b want 1", Busy_o); end
    step();
    n_cmp++; if (cur_win !== mk_win(0, 3)) begin n_bad++; $display("FAIL tail_w0 got %h want %h", cur_win, mk_win(0, 3)); end
    run(50);
    n_cmp++; if (cur_win !== mk_win(1, 3)) begin n_bad++; $display("FAIL tail_w1 got %h want %h", cur_win, mk_win(1, 3)); end
    run(100);                       // E151
    n_cmp++; if (cur_win !== 120'd0) begin n_bad++; $display("FAIL tail_blank got %h want 0", cur_win); end
    run(49);                        // E200
    n_cmp++; if ({Done_o, Busy_o} !== 2'b10) begin n_bad++; $display("FAIL tail_done got %b want 10", {Done_o, Busy_o}); end
  endtask
`endif

  initial begin
    test_reset();
`ifdef LCD_SCROLLER_TAIL_EN
    test_tail();
`else
    test_static();
    test_single_pass();
    test_loop_stop();
    test_full_clear();
    test_reset_conflicts();
    test_write_start();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
